cplx_mult_stream: RTL and testbench
===================================

Name: cplx_mult_stream

Overview:
- Multi-lane streaming fp32 complex multiplier: out = in0 × in1, or in0 × conj(in1) per lane.
- Sits between FFT/convolution stages and the accumulator.
- Wraps the existing fp32 cores (multfp32fp32 8 cycles, addfp32/subfp32 11 cycles) with valid/ready handshakes, credit-based backpressure and an output FIFO.
- Successor to the fixed single-lane, handshake-free complex multipliers: adds lanes, architecture selection, conjugate mode, a last-flag and stall-free flow control.

Parameters:
- LANES, 4, number of parallel complex multipliers sharing one handshake.
- ARCH, 0, 0 = conventional (4 mult, 1 add, 1 sub; LAT = 19); 1 = canonical (3 mult, 3 add/sub, operand delay 11; LAT = 30).
- FIFO_DEPTH, 32, output FIFO entries; must be ≥ 2; full throughput requires ≥ LAT+1.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in0  in  64*LANES  lane k at [64k+63:64k]; {r[63:32], i[31:0]} (complex_t)
- in1  in  64*LANES  same packing as in0
- conj_mask  in  LANES  bit k = 1: lane k uses conj(in1)
- in_last  in  1  end-of-block tag, carried through unchanged
- out_valid  out  1  result beat valid
- out_ready  in  1  sink ready
- out_data  out  64*LANES  products, same packing as in0
- out_last  out  1  delayed in_last
- stat_beats  out  32  accepted beats (CPLX_MULT_STATS_EN only)
- stat_stalls  out  32  stall cycles (CPLX_MULT_STATS_EN only)

Behaviour:
- Reset values:
  - out_valid = 0, out_data = 0, out_last = 0, in_ready = 1.
  - Credit counter, FIFO pointers and counts, and the valid/last shift register are cleared.
  - Datapath pipelines are not reset.
- Conjugate: lane k with conj_mask[k] = 1 inverts bit 31 of in1.i before the cores. No other change.
- Datapath enable is always 1; the pipeline never stalls.
- A LAT-stage shift register carries {valid, last} alongside the data.
- At LAT, a valid beat writes {last, all lanes} into the FIFO.
- Credit counter `used` (0..FIFO_DEPTH):
  - +1 on accept, −1 on pop, net 0 when both occur in the same cycle.
  - in_ready = (used < FIFO_DEPTH), combinational from the registered counter.
  - The FIFO therefore can never overflow.
- Latency:
  - A beat accepted at edge t is written at edge t+LAT.
  - out_valid is high after edge t+LAT; minimum accept-to-out_valid is LAT+1 cycles (20 for ARCH=0, 31 for ARCH=1).
  - With out_ready held at 1 and FIFO_DEPTH ≥ LAT+1, one beat per cycle is sustained.
- Output:
  - out_valid = FIFO not empty.
  - out_data/out_last come from the FIFO head; out_data is forced to 0 while out_valid = 0.
  - Pop on out_valid && out_ready.
- FIFO edge cases:
  - Empty FIFO: a write in a given cycle is visible next cycle (no bypass).
  - Full FIFO with simultaneous write and pop: not reachable by the credit rule.
- Pointers: binary, wrap modulo FIFO_DEPTH. Non-power-of-2 depths are supported via compare-and-clear.
- in_valid while in_ready = 0: the beat is not taken; the source must hold it.
- Reset mid-operation:
  - In-flight and buffered beats are discarded.
  - in_ready returns to 1 asynchronously.
  - Pipeline garbage is ignored because the valid shift register is cleared.
- Arithmetic: exactly that of the fp32 cores (truncating, no denormals, flush-to-zero).

Optional Feature:
- CPLX_MULT_STATS_EN defined:
  - stat_beats counts accepts.
  - stat_stalls counts cycles with in_valid && !in_ready.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: both ports and their counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cplx_pkg:
  - complex_t typedef {logic [31:0] r, i}.
  - FP_MULT_LAT = 8, FP_ADD_LAT = 11.
  - LAT_CONV = 19, LAT_CANON = 30.
  - FP_SIGN_MASK = 32'h80000000.
- One sub-module: cplx_mult_lane.
  - One lane, ARCH generate-selected.
  - Contains the cores and the canonical operand delay lines.
  - Instantiated LANES times.
- Top level holds the handshake, credit counter, valid/last pipe and FIFO.

Test Plan:
- Single beat, ARCH=0, lane0 in0 = {3F800000, 40000000} (1+2i), in1 = {40400000, 40800000} (3+4i), conj_mask = 0 → out {C0A00000, 41200000} (−5+10i), out_valid first seen 20 cycles after accept.
- Same operands, conj_mask[0] = 1 → {41300000, 40000000} (11+2i). Repeat with ARCH=1 → identical result, latency 31.
- Back-to-back 100 beats, out_ready = 1, FIFO_DEPTH = 32 → in_ready stays 1 and 100 outputs arrive in order on consecutive cycles; out_last matches the 100th beat.
- out_ready = 0, in_valid = 1 continuously → exactly 32 beats accepted, then in_ready = 0. Raise out_ready → one pop per cycle with in_ready back to 1 one cycle after the first pop; no beat lost or duplicated.
- Deassert reset_n with 10 beats in flight and 5 buffered → out_valid = 0 and in_ready = 1 immediately; no spurious output during the next 40 cycles.
- CPLX_MULT_STATS_EN: run the backpressure scenario → stat_beats = 32 at the stall point, stat_stalls increments each blocked cycle.

Source files
------------

// File: rtl/cplx_pkg.sv
// Shared types, latencies and the fp32 arithmetic used by the complex multiplier lanes.
// Arithmetic truncates, flushes denormals to zero and saturates overflow to infinity.
package cplx_pkg;

  typedef struct packed {
    logic [31:0] r;
    logic [31:0] i;
  } complex_t;

  localparam int unsigned FP_MULT_LAT = 8;
  localparam int unsigned FP_ADD_LAT  = 11;
  localparam int unsigned LAT_CONV    = 19;
  localparam int unsigned LAT_CANON   = 30;

  localparam logic [31:0] FP_SIGN_MASK = 32'h8000_0000;

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic        sign;
    logic [47:0] prod;
    logic [22:0] man;
    int          e;
    sign = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      man = prod[46:24];
      e   = e + 1;
    end else begin
      man = prod[45:23];
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 0) return {sign, 31'd0};
    if (e >= 255) return {sign, 8'hFF, 23'd0};
    return {sign, e[7:0], man};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [49:0] mx, my, s;
    int unsigned d;
    int          p, e;
    // x carries the larger magnitude, so the result takes its sign
    if (a[30:0] >= b[30:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    if (x[30:23] == 8'd0) return 32'd0;
    if (y[30:23] == 8'd0) return x;
    d  = 32'(x[30:23]) - 32'(y[30:23]);
    mx = {2'b01, x[22:0], 25'd0};
    my = {2'b01, y[22:0], 25'd0};
    my = (d > 32'd49) ? 50'd0 : (my >> d);
    s  = (x[31] == y[31]) ? (mx + my) : (mx - my);
    if (s == 50'd0) return 32'd0;
    p = 0;
    for (int k = 0; k < 50; k++) begin
      if (s[k]) p = k;
    end
    e = int'(x[30:23]) + p - 48;
    s = s << (49 - p);
    if (e <= 0) return 32'd0;
    if (e >= 255) return {x[31], 8'hFF, 23'd0};
    return {x[31], e[7:0], s[48:26]};
  endfunction

  function automatic logic [31:0] fp_sub(input logic [31:0] a, input logic [31:0] b);
    return fp_add(a, b ^ FP_SIGN_MASK);
  endfunction

endpackage

// File: rtl/cplx_mult_lane.sv
// One complex multiplier lane: p = a * b (or a * conj(b)), conventional (ARCH=0, 19 cycles)
// or canonical three-multiplier form (ARCH=1, 30 cycles). Free-running, no reset.
module cplx_mult_lane import cplx_pkg::*; #(
  parameter int unsigned ARCH = 0
) (
  input  logic     clk_i,
  input  complex_t a_i,
  input  complex_t b_i,
  input  logic     conj_i,
  output complex_t p_o
);

  complex_t b_eff;

  always_comb begin
    b_eff = b_i;
    if (conj_i) b_eff.i = b_i.i ^ FP_SIGN_MASK;
  end

  if (ARCH == 0) begin : g_conv
    logic [3:0][31:0] mul_d;
    logic [3:0][31:0] mul_q [FP_MULT_LAT];
    complex_t         sum_d;
    complex_t         sum_q [FP_ADD_LAT];

    always_comb begin
      mul_d[0] = fp_mul(a_i.r, b_eff.r);
      mul_d[1] = fp_mul(a_i.i, b_eff.i);
      mul_d[2] = fp_mul(a_i.r, b_eff.i);
      mul_d[3] = fp_mul(a_i.i, b_eff.r);
      sum_d.r  = fp_sub(mul_q[FP_MULT_LAT-1][0], mul_q[FP_MULT_LAT-1][1]);
      sum_d.i  = fp_add(mul_q[FP_MULT_LAT-1][2], mul_q[FP_MULT_LAT-1][3]);
    end

    always_ff @(posedge clk_i) begin
      mul_q[0] <= mul_d;
      for (int s = 1; s < FP_MULT_LAT; s++) mul_q[s] <= mul_q[s-1];
      sum_q[0] <= sum_d;
      for (int s = 1; s < FP_ADD_LAT; s++) sum_q[s] <= sum_q[s-1];
    end

    assign p_o = sum_q[FP_ADD_LAT-1];
  end else begin : g_canon
    // (a+bi)(c+di): k1 = c(a+b), k2 = a(d-c), k3 = b(c+d); re = k1-k3, im = k1+k2
    logic [2:0][31:0] pre_d, opd_d;
    logic [2:0][31:0] pre_q [FP_ADD_LAT];
    logic [2:0][31:0] opd_q [FP_ADD_LAT];
    logic [2:0][31:0] mul_d;
    logic [2:0][31:0] mul_q [FP_MULT_LAT];
    complex_t         sum_d;
    complex_t         sum_q [FP_ADD_LAT];

    always_comb begin
      pre_d[0] = fp_add(a_i.r, a_i.i);
      pre_d[1] = fp_sub(b_eff.i, b_eff.r);
      pre_d[2] = fp_add(b_eff.r, b_eff.i);
      opd_d    = {b_eff.r, a_i.r, a_i.i};
      mul_d[0] = fp_mul(opd_q[FP_ADD_LAT-1][2], pre_q[FP_ADD_LAT-1][0]);
      mul_d[1] = fp_mul(opd_q[FP_ADD_LAT-1][1], pre_q[FP_ADD_LAT-1][1]);
      mul_d[2] = fp_mul(opd_q[FP_ADD_LAT-1][0], pre_q[FP_ADD_LAT-1][2]);
      sum_d.r  = fp_sub(mul_q[FP_MULT_LAT-1][0], mul_q[FP_MULT_LAT-1][2]);
      sum_d.i  = fp_add(mul_q[FP_MULT_LAT-1][0], mul_q[FP_MULT_LAT-1][1]);
    end

    always_ff @(posedge clk_i) begin
      pre_q[0] <= pre_d;
      opd_q[0] <= opd_d;
      for (int s = 1; s < FP_ADD_LAT; s++) begin
        pre_q[s] <= pre_q[s-1];
        opd_q[s] <= opd_q[s-1];
      end
      mul_q[0] <= mul_d;
      for (int s = 1; s < FP_MULT_LAT; s++) mul_q[s] <= mul_q[s-1];
      sum_q[0] <= sum_d;
      for (int s = 1; s < FP_ADD_LAT; s++) sum_q[s] <= sum_q[s-1];
    end

    assign p_o = sum_q[FP_ADD_LAT-1];
  end

endmodule

// File: rtl/cplx_mult_stream.sv
// Multi-lane streaming fp32 complex multiplier with credit flow control and output FIFO.
// Optional CPLX_MULT_STATS_EN adds saturating accept/stall counters.
module cplx_mult_stream import cplx_pkg::*; #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned ARCH       = 0,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64*LANES-1:0]  in0,
  input  logic [64*LANES-1:0]  in1,
  input  logic [LANES-1:0]     conj_mask,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [64*LANES-1:0]  out_data,
  output logic                 out_last
`ifdef CPLX_MULT_STATS_EN
  ,
  output logic [31:0]          stat_beats,
  output logic [31:0]          stat_stalls
`endif
);

  localparam int unsigned LAT  = (ARCH == 0) ? LAT_CONV : LAT_CANON;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DW   = 64 * LANES;

  logic                accept, pop, wr_en;
  logic [CntW-1:0]     used_q, used_d, cnt_q, cnt_d;
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LAT-1:0]      vld_q, vld_d, lst_q, lst_d;
  logic [DW-1:0]       lane_out;
  logic [DW:0]         mem_q [FIFO_DEPTH];
  logic [DW:0]         head;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cplx_mult_lane #(
      .ARCH (ARCH)
    ) u_lane (
      .clk_i  (clk),
      .a_i    (in0[64*k +: 64]),
      .b_i    (in1[64*k +: 64]),
      .conj_i (conj_mask[k]),
      .p_o    (lane_out[64*k +: 64])
    );
  end

  // Credits cover every beat in flight or buffered, so the FIFO cannot overflow
  assign in_ready  = (used_q < CntW'(FIFO_DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  assign wr_en     = vld_q[LAT-1];

  always_comb begin
    used_d   = used_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = {vld_q[LAT-2:0], accept};
    lst_d    = {lst_q[LAT-2:0], accept & in_last};
    case ({accept, pop})
      2'b10:   used_d = used_q + CntW'(1);
      2'b01:   used_d = used_q - CntW'(1);
      default: ;
    endcase
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: ;
    endcase
    if (wr_en) wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    if (pop)   rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      used_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
      lst_q    <= '0;
    end else begin
      used_q   <= used_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
      lst_q    <= lst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {lst_q[LAT-1], lane_out};
  end

  assign head     = mem_q[rd_ptr_q];
  assign out_data = out_valid ? head[DW-1:0] : '0;
  assign out_last = out_valid & head[DW];

`ifdef CPLX_MULT_STATS_EN
  logic [31:0] beats_q, beats_d, stalls_q, stalls_d;

  always_comb begin
    beats_d  = beats_q;
    stalls_d = stalls_q;
    if (accept && beats_q != '1) beats_d = beats_q + 32'd1;
    if (in_valid && !in_ready && stalls_q != '1) stalls_d = stalls_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beats_q  <= '0;
      stalls_q <= '0;
    end else begin
      beats_q  <= beats_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_beats  = beats_q;
  assign stat_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_cplx_mult_stream.sv
// Directed bench for cplx_mult_stream: ARCH=0 and ARCH=1 instances share one stimulus.
// Stats checks compile in when CPLX_MULT_STATS_EN is defined.
module tb_cplx_mult_stream;
  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 64 * LANES;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic [W-1:0] in0, in1;
  logic [LANES-1:0] conj_mask;
  logic         in_last;
  logic         out_ready;
  logic         in_ready0, in_ready1, o0_valid, o1_valid, o0_last, o1_last;
  logic [W-1:0] o0_data, o1_data;
`ifdef CPLX_MULT_STATS_EN
  logic [31:0]  beats0, stalls0, beats1, stalls1;
`endif

  always #5 clk = ~clk;

  cplx_mult_stream #(.LANES(LANES), .ARCH(0), .FIFO_DEPTH(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in0(in0), .in1(in1), .conj_mask(conj_mask), .in_last(in_last),
    .out_valid(o0_valid), .out_ready(out_ready), .out_data(o0_data), .out_last(o0_last)
`ifdef CPLX_MULT_STATS_EN
    , .stat_beats(beats0), .stat_stalls(stalls0)
`endif
  );

  cplx_mult_stream #(.LANES(LANES), .ARCH(1), .FIFO_DEPTH(32)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in0(in0), .in1(in1), .conj_mask(conj_mask), .in_last(in_last),
    .out_valid(o1_valid), .out_ready(out_ready), .out_data(o1_data), .out_last(o1_last)
`ifdef CPLX_MULT_STATS_EN
    , .stat_beats(beats1), .stat_stalls(stalls1)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] lane(input logic [W-1:0] v, input int k);
    return v[64*k +: 64];
  endfunction

  // Exact fp32 encoding of a small positive integer
  function automatic logic [31:0] i2f(input int unsigned v);
    int          p;
    logic [31:0] m;
    p = 0;
    for (int b = 0; b < 32; b++) if (v[b]) p = b;
    m = v << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  // Sequence beat n: (1+1i) * ((n+1)+0i) = (n+1) + (n+1)i
  function automatic logic [63:0] eseq(input int n);
    return {i2f(n + 1), i2f(n + 1)};
  endfunction

  task automatic set_seq(input int n);
    logic [63:0] b;
    b   = {i2f(n + 1), 32'h0};
    in0 = {LANES{64'h3F800000_3F800000}};
    in1 = {LANES{b}};
  endtask

  task automatic reset_dut();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    conj_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [63:0] a_vec [LANES] = '{64'h3F800000_40000000, 64'h40000000_00000000,
                                 64'h00000000_3F800000, 64'h3F800000_3F800000};
  logic [63:0] b_vec [LANES] = '{64'h40400000_40800000, 64'h40000000_00000000,
                                 64'h00000000_3F800000, 64'h3F800000_BF800000};
  logic [63:0] p_vec [LANES] = '{64'hC0A00000_41200000, 64'h40800000_00000000,
                                 64'hBF800000_00000000, 64'h40000000_00000000};

  task automatic single_beat(input logic [LANES-1:0] mask, input logic last,
                             output int lat0, output int lat1,
                             output logic [W-1:0] d0, output logic [W-1:0] d1,
                             output logic l0, output logic l1);
    for (int k = 0; k < LANES; k++) begin
      in0[64*k +: 64] = a_vec[k];
      in1[64*k +: 64] = b_vec[k];
    end
    conj_mask = mask;
    in_last   = last;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    lat0 = 0; lat1 = 0; d0 = '0; d1 = '0; l0 = 1'b0; l1 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (o0_valid && lat0 == 0) begin lat0 = n; d0 = o0_data; l0 = o0_last; end
      if (o1_valid && lat1 == 0) begin lat1 = n; d1 = o1_data; l1 = o1_last; end
    end
    in_last   = 1'b0;
    conj_mask = '0;
  endtask

  int           lat0, lat1, acc, rcv, gaps, ready_bad, stalls, spurious;
  logic [W-1:0] d0, d1;
  logic         l0, l1, rdy;

  initial begin
    out_ready = 1'b1;
    in0 = '0;
    in1 = '0;
    reset_dut();
    check_eq("rst_out_valid", o0_valid, 1'b0);
    check_eq("rst_out_data", lane(o0_data, 0), 64'h0);
    check_eq("rst_out_last", o0_last, 1'b0);
    check_eq("rst_in_ready", in_ready0, 1'b1);
    check_eq("rst_in_ready_canon", in_ready1, 1'b1);

    // Plain product, all lanes, both architectures
    single_beat(4'b0000, 1'b1, lat0, lat1, d0, d1, l0, l1);
    check_eq("lat_conv", lat0, 20);
    check_eq("lat_canon", lat1, 31);
    for (int k = 0; k < LANES; k++) begin
      check_eq($sformatf("conv_lane%0d", k), lane(d0, k), p_vec[k]);
      check_eq($sformatf("canon_lane%0d", k), lane(d1, k), p_vec[k]);
    end
    check_eq("conv_last", l0, 1'b1);
    check_eq("canon_last", l1, 1'b1);
    check_eq("single_drained", o0_valid, 1'b0);

    // Conjugate on lane 0 only
    single_beat(4'b0001, 1'b0, lat0, lat1, d0, d1, l0, l1);
    check_eq("conj_conv_lane0", lane(d0, 0), 64'h41300000_40000000);
    check_eq("conj_canon_lane0", lane(d1, 0), 64'h41300000_40000000);
    check_eq("conj_conv_lane1", lane(d0, 1), p_vec[1]);
    check_eq("conj_lat_canon", lat1, 31);
    check_eq("conj_last", l0, 1'b0);

    // 100 back-to-back beats with the sink always ready
    reset_dut();
    out_ready = 1'b1;
    rcv = 0; gaps = 0; ready_bad = 0;
    for (int c = 0; c < 140; c++) begin
      if (c < 100) begin
        set_seq(c);
        in_last  = (c == 99);
        in_valid = 1'b1;
        if (!in_ready0) ready_bad++;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      if (o0_valid) begin
        check_eq("tput_data", lane(o0_data, 0), eseq(rcv));
        check_eq("tput_last", o0_last, (rcv == 99));
        rcv++;
      end else if (rcv > 0 && rcv < 100) begin
        gaps++;
      end
      @(posedge clk); #1;
    end
    check_eq("tput_ready_drops", ready_bad, 0);
    check_eq("tput_gaps", gaps, 0);
    check_eq("tput_count", rcv, 100);

    // Backpressure: sink blocked, source always valid
    reset_dut();
    out_ready = 1'b0;
    acc = 0; stalls = 0;
    set_seq(acc);
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      rdy = in_ready0;
      if (!rdy) stalls++;
      @(posedge clk); #1;
      if (rdy) begin acc++; set_seq(acc); end
    end
    check_eq("bp_accepted", acc, 32);
    check_eq("bp_in_ready_low", in_ready0, 1'b0);
    check_eq("bp_out_valid", o0_valid, 1'b1);
`ifdef CPLX_MULT_STATS_EN
    check_eq("stat_beats", beats0, 32);
    check_eq("stat_stalls", stalls0, 28);
    check_eq("stat_stalls_track", stalls0, stalls);
`endif
    out_ready = 1'b1;
    rcv = 0;
    for (int c = 0; c < 120; c++) begin
      if (o0_valid) begin
        check_eq("bp_data", lane(o0_data, 0), eseq(rcv));
        rcv++;
      end
      rdy = in_ready0 & in_valid;
      @(posedge clk); #1;
      if (c == 0) check_eq("bp_ready_back", in_ready0, 1'b1);
      if (rdy) begin
        acc++;
        if (acc == 40) in_valid = 1'b0;
        else set_seq(acc);
      end
    end
    check_eq("bp_count", rcv, 40);

    // Reset with 10 beats in flight and 5 buffered
    reset_dut();
    out_ready = 1'b0;
    for (int n = 0; n < 15; n++) begin
      set_seq(n);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    check_eq("mid_buffered", o0_valid, 1'b1);
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", o0_valid, 1'b0);
    check_eq("mid_rst_in_ready", in_ready0, 1'b1);
    check_eq("mid_rst_out_data", lane(o0_data, 0), 64'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    spurious  = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o0_valid || o1_valid) spurious++;
    end
    check_eq("mid_spurious", spurious, 0);
`ifdef CPLX_MULT_STATS_EN
    check_eq("stat_beats_cleared", beats0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
